// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer for a 128-word combinational instruction memory.
// Drives imem_addr from the PC, registers each fetched word toward IF/ID, and
// handles stall, branch redirect (one-bubble flush) and halt on a sentinel word.
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_sequencer #(
   parameter int unsigned       ADDR_W    = 7,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] if_instr,
   output logic [ADDR_W-1:0] if_pc,
   output logic              if_valid,
   output logic              halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   pc_inc_d;
   logic [DATA_W-1:0]   instr_q;
   logic [ADDR_W-1:0]   if_pc_q;
   logic                valid_q;
   logic                halted_q;
   logic                is_halt_word_c;

   // Sequential PC increment wraps modulo 2^ADDR_W by construction.
   assign pc_inc_d       = pc_q + ADDR_W'(1);
   assign is_halt_word_c = (imem_data == HALT_WORD);

   assign imem_addr = pc_q;
   assign if_instr  = instr_q;
   assign if_pc     = if_pc_q;
   assign if_valid  = valid_q;
   assign halted    = halted_q;

   // Fetch FSM: state, PC and IF/ID-facing registers updated together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         if_pc_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               valid_q <= 1'b0;
               if (start) begin
                  state_q <= ST_FETCH;
                  pc_q    <= RESET_PC;
               end
            end
            ST_FETCH: begin
               if (branch_taken) begin
                  // Redirect wins over stall; the in-flight word becomes a bubble.
                  pc_q    <= branch_target;
                  valid_q <= 1'b0;
               end else if (stall) begin
                  // Hold everything.
                  pc_q <= pc_q;
               end else if (is_halt_word_c) begin
                  // Halt word is swallowed; PC stays pointing at it.
                  valid_q  <= 1'b0;
                  state_q  <= ST_HALT;
                  halted_q <= 1'b1;
               end else begin
                  instr_q <= imem_data;
                  if_pc_q <= pc_q;
                  valid_q <= 1'b1;
                  pc_q    <= pc_inc_d;
               end
            end
            ST_HALT: begin
               valid_q <= 1'b0;
               if (start) begin
                  pc_q     <= RESET_PC;
                  state_q  <= ST_FETCH;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               valid_q  <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic        fetch_evt_c;
   logic        stall_evt_c;
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   assign fetch_evt_c = (state_q == ST_FETCH) && !branch_taken && !stall && !is_halt_word_c;
   assign stall_evt_c = (state_q == ST_FETCH) && !branch_taken && stall;

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;

   // Saturating event counters for completed fetches and stalled fetch cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (fetch_evt_c && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'(1);
         if (stall_evt_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'(1);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed + random stimulus for fetch_sequencer, with a
// cycle-level reference model feeding a scoreboard queue popped by a monitor.
module tb_fetch_sequencer;
   localparam int          DEPTH     = 128;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stall;
   logic        branch_taken;
   logic [6:0]  branch_target;
   logic [6:0]  imem_addr;
   logic [31:0] imem_data;
   logic [31:0] if_instr;
   logic [6:0]  if_pc;
   logic        if_valid;
   logic        halted;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   logic [31:0] mem [DEPTH];
   assign imem_data = mem[imem_addr];

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .if_valid      (if_valid),
      .halted        (halted)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   typedef struct {
      bit        valid;
      bit [31:0] instr;
      bit [6:0]  pc;
      bit [6:0]  addr;
      bit        halted;
      bit [31:0] fcnt;
      bit [31:0] scnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: 0 idle, 1 fetching, 2 halted.
   int        m_state;
   int        m_pc;
   bit [31:0] m_instr;
   int        m_ifpc;
   bit        m_valid;
   longint    m_fcnt;
   longint    m_scnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_state = 0; m_pc = 0; m_instr = '0; m_ifpc = 0; m_valid = 1'b0;
      m_fcnt = 0; m_scnt = 0;
   endfunction

   function automatic void model_step(input bit s, input bit st, input bit br, input int tgt);
      bit [31:0] word;
      word = mem[m_pc];
      if (m_state == 0) begin
         m_valid = 1'b0;
         if (s) begin m_state = 1; m_pc = 0; end
      end else if (m_state == 1) begin
         if (br) begin
            m_pc = tgt; m_valid = 1'b0;
         end else if (st) begin
            m_scnt++;
         end else if (word == HALT_WORD) begin
            m_valid = 1'b0; m_state = 2;
         end else begin
            m_instr = word; m_ifpc = m_pc; m_valid = 1'b1;
            m_pc = (m_pc + 1) % DEPTH;
            m_fcnt++;
         end
      end else begin
         m_valid = 1'b0;
         if (s) begin m_pc = 0; m_state = 1; end
      end
   endfunction

   // One clock of stimulus; the expected post-edge view goes to the scoreboard.
   task automatic cyc(input bit s, input bit st, input bit br, input int tgt);
      exp_t e;
      @(negedge clk);
      start = s; stall = st; branch_taken = br; branch_target = 7'(tgt);
      model_step(s, st, br, tgt);
      e.valid  = m_valid;
      e.instr  = m_instr;
      e.pc     = 7'(m_ifpc);
      e.addr   = 7'(m_pc);
      e.halted = (m_state == 2);
      e.fcnt   = (m_fcnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_fcnt);
      e.scnt   = (m_scnt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_scnt);
      sb_q.push_back(e);
   endtask

   // Asynchronous reset mid-stream: outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      rst = 1'b1;
      #1;
      chk("rst_if_valid", 64'(if_valid), 64'(0));
      chk("rst_imem_addr", 64'(imem_addr), 64'(0));
      chk("rst_halted", 64'(halted), 64'(0));
      chk("rst_if_instr", 64'(if_instr), 64'(0));
      chk("rst_if_pc", 64'(if_pc), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   function automatic bit [31:0] rand_word();
      bit [31:0] w;
      w = $urandom;
      if (w == HALT_WORD) w = 32'h0;
      return w;
   endfunction

   // Monitor: compare each cycle's DUT view against the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("if_valid", 64'(if_valid), 64'(e.valid));
         chk("imem_addr", 64'(imem_addr), 64'(e.addr));
         chk("halted", 64'(halted), 64'(e.halted));
         if (e.valid) begin
            chk("if_instr", 64'(if_instr), 64'(e.instr));
            chk("if_pc", 64'(if_pc), 64'(e.pc));
         end
`ifdef FETCH_PERF_EN
         chk("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(e.fcnt));
         chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(e.scnt));
`endif
      end
   end

   initial begin
      int budget;
      rst = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
      model_reset();
      do_reset();

      // Straight-line fetch of A,B,C,D.
      mem[0] = 32'hA000_000A; mem[1] = 32'hB000_000B;
      mem[2] = 32'hC000_000C; mem[3] = 32'hD000_000D;
      cyc(1, 0, 0, 0);
      repeat (4) cyc(0, 0, 0, 0);

      // Stall three cycles at pc=2, then resume.
      do_reset();
      cyc(1, 0, 0, 0);
      repeat (2) cyc(0, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 0);
      repeat (2) cyc(0, 0, 0, 0);
      // Branch beats a simultaneous stall.
      cyc(0, 1, 1, 40);
      repeat (2) cyc(0, 0, 0, 0);

      // Halt word at 5; branch/stall ignored while halted; restart from 0.
      do_reset();
      mem[5] = HALT_WORD;
      cyc(1, 0, 0, 0);
      repeat (8) cyc(0, 0, 0, 0);
      cyc(0, 1, 1, 9);
      cyc(1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0);
      mem[5] = rand_word();

      // Wrap-around from 126, then reset in the middle of the stream.
      cyc(0, 0, 1, 126);
      repeat (5) cyc(0, 0, 0, 0);
      do_reset();

      // Four fetches and three stall cycles from a clean reset.
      cyc(1, 0, 0, 0);
      repeat (4) cyc(0, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);

      // Randomized run with a few halt words planted.
      do_reset();
      for (int i = 0; i < 3; i++) mem[$urandom_range(DEPTH - 1)] = HALT_WORD;
      for (int i = 0; i < 500; i++) begin
         cyc(($urandom_range(7) == 0), ($urandom_range(3) == 0),
             ($urandom_range(7) == 0), int'($urandom_range(DEPTH - 1)));
         if (i == 250) begin
            do_reset();
         end
      end

      budget = 0;
      while (sb_q.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (sb_q.size() > 0) chk("scoreboard_drain", 64'(sb_q.size()), 64'(0));
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
